// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one UART transmitter among NREQ byte-lane reporters.
// Define ARB_TIMEOUT_EN to build the idle-lock timeout; without it timeout_err is tied low.

module uart_tx_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_byte,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ack,
  output logic [7:0]        tx_byte,
  output logic              tx_req,
  input  logic              tx_busy,
  output logic              grant_active,
  output logic [IDW-1:0]    grant_id,
  output logic              timeout_err
);

  typedef enum logic [1:0] {StIdle, StLocked, StGuard} state_e;

  state_e state_q, state_d;

  logic [IDW-1:0]  last_grant_q, last_grant_d;
  logic [IDW-1:0]  grant_id_q, grant_id_d;
  logic            grant_active_q, grant_active_d;
  logic            release_q, release_d;
  logic            tx_req_q, tx_req_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic [NREQ-1:0] req_ack_q, req_ack_d;
  logic            timeout_err_q, timeout_err_d;

  logic            any_valid;
  logic            sel_valid;
  logic            sel_last;
  logic [7:0]      sel_byte;
  logic            accept;
  logic            to_fire;
  logic            found;
  logic [IDW-1:0]  winner;
  logic [IDW-1:0]  cand_id;
  int unsigned     cand;

  assign any_valid = |req_valid;
  assign sel_valid = req_valid[grant_id_q];
  assign sel_last  = req_last[grant_id_q];
  assign sel_byte  = req_byte[8*grant_id_q +: 8];
  assign accept    = (state_q == StLocked) && sel_valid && !tx_busy;

  // Round-robin search starting just after the previous grant, wrapping modulo NREQ.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    cand    = 0;
    cand_id = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand    = (32'(last_grant_q) + k) % NREQ;
      cand_id = IDW'(cand);
      if (!found && req_valid[cand_id]) begin
        found  = 1'b1;
        winner = cand_id;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [15:0] to_cnt_q, to_cnt_d;

  // Counts starved LOCKED cycles; a busy UART with a valid lane does not count as starvation.
  always_comb begin
    to_cnt_d = to_cnt_q;
    to_fire  = 1'b0;
    if (state_q != StLocked || accept) begin
      to_cnt_d = '0;
    end else if (!sel_valid) begin
      if ({1'b0, to_cnt_q} + 17'd1 == 17'(TIMEOUT)) begin
        to_fire  = 1'b1;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign to_fire = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (any_valid) state_d = StLocked;
      end
      StLocked: begin
        if (accept) begin
          state_d = StGuard;
        end else if (to_fire) begin
          state_d = StIdle;
        end
      end
      StGuard: begin
        state_d = release_q ? StIdle : StLocked;
      end
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs and grant bookkeeping.
  always_comb begin
    last_grant_d   = last_grant_q;
    grant_id_d     = grant_id_q;
    grant_active_d = grant_active_q;
    release_d      = release_q;
    tx_byte_d      = tx_byte_q;
    tx_req_d       = 1'b0;
    req_ack_d      = '0;
    timeout_err_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (any_valid) begin
          grant_id_d     = winner;
          last_grant_d   = winner;
          grant_active_d = 1'b1;
        end
      end
      StLocked: begin
        if (accept) begin
          tx_byte_d = sel_byte;
          tx_req_d  = 1'b1;
          release_d = sel_last;
          for (int unsigned i = 0; i < NREQ; i++) begin
            req_ack_d[i] = (grant_id_q == IDW'(i));
          end
        end else if (to_fire) begin
          timeout_err_d  = 1'b1;
          grant_active_d = 1'b0;
        end
      end
      StGuard: begin
        if (release_q) grant_active_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      last_grant_q   <= IDW'(NREQ - 1);
      grant_id_q     <= '0;
      grant_active_q <= 1'b0;
      release_q      <= 1'b0;
      tx_byte_q      <= 8'h00;
      tx_req_q       <= 1'b0;
      req_ack_q      <= '0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      grant_id_q     <= grant_id_d;
      grant_active_q <= grant_active_d;
      release_q      <= release_d;
      tx_byte_q      <= tx_byte_d;
      tx_req_q       <= tx_req_d;
      req_ack_q      <= req_ack_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign req_ack      = req_ack_q;
  assign tx_byte      = tx_byte_q;
  assign tx_req       = tx_req_q;
  assign grant_active = grant_active_q;
  assign grant_id     = grant_id_q;
  assign timeout_err  = timeout_err_q;

endmodule
